// File: rtl/uart_output_manager.sv
// uart_output_manager: sends a DIGIT_COUNT-nibble value as uppercase ASCII hex
// over an 8N1 UART line, nibble 0 first, optionally followed by CR LF.
module uart_output_manager #(
    parameter int CLOCK_RATE  = 100_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DIGIT_COUNT = 4,
    parameter int SEND_CRLF   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIGIT_COUNT*4-1:0] in,
    input  logic                     start,
    output logic                     RsTx,
    output logic                     busy,
    output logic                     done
);

    localparam int BIT_TICKS = CLOCK_RATE / BAUD_RATE;
    localparam int N_CHARS   = DIGIT_COUNT + ((SEND_CRLF != 0) ? 2 : 0);
    localparam int TICK_W    = $clog2(BIT_TICKS);
    localparam int CHAR_W    = $clog2(N_CHARS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(N_CHARS - 1);
    localparam logic [CHAR_W-1:0] CHAR_CR   = CHAR_W'(DIGIT_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA,
        STOP_BIT
    } state_t;

    state_t                   state_q, state_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [2:0]               bit_q, bit_d;
    logic [CHAR_W-1:0]        char_q, char_d;
    logic [DIGIT_COUNT*4-1:0] value_q, value_d;
    logic                     tx_q, tx_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [3:0]               nibble;
    logic [7:0]               char_byte;

    // Select the byte for the current character: a hex digit, then CR, then LF.
    always_comb begin
        nibble    = 4'h0;
        char_byte = 8'h0A;
        for (int k = 0; k < DIGIT_COUNT; k++) begin
            if (char_q == CHAR_W'(k)) begin
                nibble = value_q[4*k +: 4];
            end
        end
        if (char_q < CHAR_CR) begin
            if (nibble < 4'd10) begin
                char_byte = 8'h30 + {4'h0, nibble};
            end else begin
                char_byte = 8'h37 + {4'h0, nibble};
            end
        end else if (char_q == CHAR_CR) begin
            char_byte = 8'h0D;
        end
    end

    // Next-state logic: frame sequencing, bit timing and the registered line value.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        char_d  = char_q;
        value_d = value_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = in;
                    state_d = START_BIT;
                    tick_d  = '0;
                    bit_d   = '0;
                    char_d  = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START_BIT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = char_byte[0];
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DATA: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = char_byte[bit_q + 3'd1];
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            STOP_BIT: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (char_q == CHAR_LAST) begin
                        state_d = IDLE;
                        char_d  = '0;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        char_d  = char_q + 1'b1;
                        state_d = START_BIT;
                        tx_d    = 1'b0;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                bit_d   = '0;
                char_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset forces the line idle immediately and aborts any transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            char_q  <= '0;
            value_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            value_q <= value_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RsTx = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/uart_output_manager.md
# uart_output_manager

Transmit-side counterpart of the UART input manager. The block captures a DIGIT_COUNT-nibble value on a start strobe and converts each nibble to an uppercase ASCII hex character. It sends the characters over a single 8N1 UART line, optionally followed by CR LF. Digits go out in the same order the input manager stores them: nibble 0 first. A loopback of RsTx into the input manager therefore reconstructs the original value.

## Interface
- CLOCK_RATE, 100_000_000, clk frequency in Hz
- BAUD_RATE, 9600, line rate; BIT_TICKS = CLOCK_RATE / BAUD_RATE (integer division, must be ≥ 2)
- DIGIT_COUNT, 4, number of hex digits sent per transfer (≥ 1)
- SEND_CRLF, 1, when 1 append 0x0D then 0x0A after the digits; when 0 send digits only
- clk  input  1  system clock; all logic on posedge clk
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in  input  DIGIT_COUNT*4  value to transmit; sampled only on an accepted start
- start  input  1  request strobe; accepted on any clk edge where busy = 0
- RsTx  output  1  serial line; idle high
- busy  output  1  high from the cycle after an accepted start until the final stop bit ends
- done  output  1  one-cycle pulse marking completion of a transfer

## Operation
- Character count per transfer: N = DIGIT_COUNT + (SEND_CRLF ? 2 : 0).
- Character k for k < DIGIT_COUNT is nibble in[4k+3:4k]:
  - values 0–9 map to 0x30–0x39
  - values A–F map to 0x41–0x46
- Character DIGIT_COUNT is 0x0D and character DIGIT_COUNT+1 is 0x0A (SEND_CRLF = 1 only).
- Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1). There is no parity.
- Characters are sent back-to-back. The next start bit directly follows the previous stop bit, with no idle gap.
- State machine:
  - IDLE → START_BIT on an accepted start.
  - START_BIT → DATA after BIT_TICKS cycles.
  - DATA → STOP_BIT after 8 × BIT_TICKS cycles.
  - STOP_BIT → START_BIT after BIT_TICKS cycles if characters remain; otherwise STOP_BIT → IDLE with done pulsed.
- Counters:
  - baud tick counter: width clog2(BIT_TICKS), counts 0..BIT_TICKS-1 and wraps
  - bit index: 0..7
  - character index: clog2(N+1) bits
- `in` is copied into an internal shift/hold register on acceptance. Later changes to `in` do not affect the transfer in progress.
- start while busy = 1 is ignored and not queued.
- start in the same cycle done = 1 is accepted, because busy = 0 in that cycle.
- Reset values: RsTx = 1, busy = 0, done = 0, state IDLE, all counters 0.
- Asserting reset mid-transfer aborts it immediately:
  - RsTx goes to 1 asynchronously and no done pulse is generated.
  - After release, the block waits in IDLE for a new start.

## Timing
- Start sampled at edge E0. At edge E0+1, RsTx drops to 0 and busy rises.
- RsTx is a registered output and is glitch-free.
- Every bit holds for exactly BIT_TICKS cycles.
- The transfer occupies 10 × N × BIT_TICKS cycles, starting at E0+1.
- At edge E0+1+10·N·BIT_TICKS: done = 1 for one cycle, busy = 0, RsTx = 1. This is the same edge where the last stop bit ends.
- Latency from start to first start bit is 1 cycle. No cycles are lost between characters.

## Test plan
Bench parameters: CLOCK_RATE = 16 and BAUD_RATE = 1, giving BIT_TICKS = 16.
- Reset applied asynchronously between edges -> RsTx = 1, busy = 0, done = 0 immediately; the line stays idle for 100 cycles with no start.
- in = 16'h12AF, start for 1 cycle, SEND_CRLF = 1 -> decoded bytes are 0x46, 0x41, 0x32, 0x31, 0x0D, 0x0A. Each bit lasts 16 cycles. done is a single pulse at E0+961, and busy is high over E0+1..E0+960.
- SEND_CRLF = 0, in = 16'h0009 -> bytes 0x39, 0x30, 0x30, 0x30. done at E0+641.
- After start, change in to 16'hFFFF and pulse start again at E0+100 -> the transmission is unchanged (original bytes only). No second transfer follows.
- Reset asserted at E0+250 during byte 1, released 20 cycles later -> RsTx = 1 and busy = 0 at once, and no done pulse. A new start with in = 16'h0000 then yields 0x30 ×4 + CR LF from the first character.
- start held high continuously from E0 -> a second transfer is accepted at the done edge. Its start bit appears at the following edge (1 idle-high cycle between transfers), and done pulses once per transfer.
